// File: rtl/banco_writeback_pkg.sv
// rtl/banco_writeback_pkg.sv - shared constants and entry layout for the bank write-back path
package banco_writeback_pkg;

   localparam int WB_WIDTH    = 8;
   localparam int WB_NREG     = 4;
   localparam int WB_RD_W     = 2;

   // Entry record is {rd, data}: data in the low bits, rd directly above it.
   localparam int WB_DATA_OFS = 0;
   localparam int WB_RD_OFS   = WB_DATA_OFS + WB_WIDTH;
   localparam int WB_ENT_W    = WB_RD_OFS + WB_RD_W;

endpackage

// File: rtl/banco_writeback_fila_wb.sv
// rtl/banco_writeback_fila_wb.sv - generic circular FIFO with per-entry tag visibility
module fila_wb #(
   parameter int W     = 10,
   parameter int DEPTH = 4,
   parameter int TW    = 2,
   localparam int PW   = $clog2(DEPTH)
) (
   input  logic                       clk,
   input  logic                       r,
   input  logic                       push,
   input  logic [W-1:0]               din,
   input  logic                       pop,
   output logic [W-1:0]               head,
   output logic                       cheio,
   output logic                       vazio,
   output logic [DEPTH-1:0][TW-1:0]   tags,
   output logic [DEPTH-1:0]           tag_valid
);

   logic [DEPTH-1:0][W-1:0] mem;
   logic [PW-1:0]           wptr;
   logic [PW-1:0]           rptr;
   logic [PW:0]             cnt;
   logic                    do_push;
   logic                    do_pop;
   logic [PW-1:0]           off;

   assign cheio   = (cnt == (PW+1)'(DEPTH));
   assign vazio   = (cnt == '0);
   assign do_pop  = pop && !vazio;
   // A pop in the same cycle frees the slot the push is about to take.
   assign do_push = push && (!cheio || do_pop);
   assign head    = mem[rptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wptr] <= din;
      end
   end

   always_ff @(posedge clk or negedge r) begin
      if (!r) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
      end else begin
         if (do_push) begin
            wptr <= wptr + 1'b1;
         end
         if (do_pop) begin
            rptr <= rptr + 1'b1;
         end
         if (do_push && !do_pop) begin
            cnt <= cnt + 1'b1;
         end else if (do_pop && !do_push) begin
            cnt <= cnt - 1'b1;
         end
      end
   end

   // Slot i holds a live entry when its distance from the read pointer is below the count.
   always_comb begin
      tags      = '0;
      tag_valid = '0;
      off       = '0;
      for (int i = 0; i < DEPTH; i++) begin
         tags[i]      = mem[i][W-1 -: TW];
         off          = PW'(i) - rptr;
         tag_valid[i] = ({1'b0, off} < cnt);
      end
   end

endmodule

// File: rtl/banco_writeback.sv
// rtl/banco_writeback.sv - write-side front end of the 4x8 register bank
module banco_writeback
   import banco_writeback_pkg::*;
#(
   parameter int WIDTH = WB_WIDTH,
   parameter int DEPTH = 4,
   parameter int NREG  = WB_NREG
) (
   input  logic               clk,
   input  logic               r,
   input  logic               alu_valid,
   input  logic [1:0]         alu_rd,
   input  logic [WIDTH-1:0]   alu_dado,
   output logic               alu_ready,
   input  logic               mem_valid,
   input  logic [1:0]         mem_rd,
   input  logic [WIDTH-1:0]   mem_dado,
   output logic               mem_ready,
   input  logic               porta_ocupada,
   output logic [WIDTH-1:0]   dado,
   output logic [1:0]         ra,
   output logic               rw,
   output logic [NREG-1:0]    pend,
   output logic               cheio,
   output logic               vazio
);

   localparam int ENT_W  = WIDTH + WB_RD_W;
   localparam int RD_OFS = WB_DATA_OFS + WIDTH;

   logic [ENT_W-1:0]                 din;
   logic [ENT_W-1:0]                 head;
   logic                             push;
   logic                             pop;
   logic                             cheio_eff;
   logic [DEPTH-1:0][WB_RD_W-1:0]    tags;
   logic [DEPTH-1:0]                 tag_valid;

   fila_wb #(
      .W     (ENT_W),
      .DEPTH (DEPTH),
      .TW    (WB_RD_W)
   ) u_fila (
      .clk       (clk),
      .r         (r),
      .push      (push),
      .din       (din),
      .pop       (pop),
      .head      (head),
      .cheio     (cheio),
      .vazio     (vazio),
      .tags      (tags),
      .tag_valid (tag_valid)
   );

   // Port A belongs to decode while porta_ocupada is high, so writes wait.
   assign pop       = !vazio && !porta_ocupada;
   assign rw        = pop;
   assign cheio_eff = cheio && !pop;

   // Readies are held low while reset is asserted; memory loads win over ALU results.
   assign mem_ready = r && !cheio_eff;
   assign alu_ready = r && !cheio_eff && !mem_valid;

   assign push = (mem_valid && mem_ready) || (alu_valid && alu_ready);

   always_comb begin
      din = '0;
      if (mem_valid) begin
         din[RD_OFS +: WB_RD_W]    = mem_rd;
         din[WB_DATA_OFS +: WIDTH] = mem_dado;
      end else begin
         din[RD_OFS +: WB_RD_W]    = alu_rd;
         din[WB_DATA_OFS +: WIDTH] = alu_dado;
      end
   end

   always_comb begin
      dado = '0;
      ra   = '0;
      if (!vazio) begin
         dado = head[WB_DATA_OFS +: WIDTH];
         ra   = head[RD_OFS +: WB_RD_W];
      end
   end

   always_comb begin
      pend = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (tag_valid[i]) begin
            pend[tags[i]] = 1'b1;
         end
      end
   end

endmodule

// File: doc/banco_writeback.md
Name: banco_writeback

Overview:
- Write-side front end of the 4x8 register bank.
- Collects results from the ALU and memory paths through valid/ready handshakes and buffers them in a small in-order FIFO.
- Replays them to the bank as single-cycle write strobes (`dado`, write address, `rw`).
- The bank shares port A between reads and writes, so the block holds writes off while the decode stage owns port A (`porta_ocupada`). It also exports a pending-register mask for hazard detection.

Parameters:
- WIDTH, 8, data width of a register.
- DEPTH, 4, FIFO entries; must be a power of 2, at least 2.
- NREG, 4, number of bank registers (address width 2).

Ports:
- clk  in  1  clock; all state updates on posedge.
- r  in  1  reset; asynchronous, active-low.
- alu_valid  in  1  ALU result offered.
- alu_rd  in  2  ALU destination register.
- alu_dado  in  WIDTH  ALU result.
- alu_ready  out  1  ALU result accepted this cycle.
- mem_valid  in  1  memory load result offered.
- mem_rd  in  2  memory destination register.
- mem_dado  in  WIDTH  load data.
- mem_ready  out  1  memory result accepted this cycle.
- porta_ocupada  in  1  decode stage is using bank port A this cycle; no write may issue.
- dado  out  WIDTH  write data to the bank.
- ra  out  2  write address to the bank.
- rw  out  1  write strobe to the bank.
- pend  out  NREG  bit i=1 while any queued entry targets register i.
- cheio  out  1  FIFO full.
- vazio  out  1  FIFO empty.

Behaviour:
- Reset (r=0, async):
  - FIFO cleared: pointers and count 0.
  - `rw`=0, `dado`=0, `ra`=0, `pend`=0, `cheio`=0, `vazio`=1, `alu_ready`=0, `mem_ready`=0.
  - Takes effect immediately, mid-burst included; queued writes are discarded.
- FIFO: circular buffer of {rd[1:0], data[WIDTH-1:0]}.
  - Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - Count is log2(DEPTH)+1 bits.
- Acceptance: at most one push per cycle; memory has priority over ALU.
  - `mem_ready` = !cheio_eff.
  - `alu_ready` = !cheio_eff && !mem_valid.
  - cheio_eff = count==DEPTH and no pop this cycle. A pop frees its slot for a same-cycle push.
  - Push happens on the edge where valid && ready.
- Issue: a pop occurs in every cycle with !vazio && !porta_ocupada.
  - `rw` = pop (combinational).
  - `dado` and `ra` = FIFO head fields whenever !vazio, else 0.
  - The bank samples the write on the same edge the entry is popped.
- Latency: a result accepted at edge k into an empty FIFO drives `rw`=1 in the cycle after k if `porta_ocupada`=0. The bank is updated at edge k+1.
- Simultaneous push and pop: count unchanged; both pointers advance. With count==DEPTH, this is the only way to accept.
- Ordering: strictly FIFO. Two queued writes to the same register land in arrival order, so the last one wins.
- `pend`: combinational OR over valid entries of onehot(rd). It does not include an entry arriving this cycle; an entry popped this cycle still counts until the edge.
- `porta_ocupada` held high: no pops; FIFO fills; both readies drop at count==DEPTH; no data lost.
- Width: data is never modified; rd is taken verbatim, with no range check needed since NREG=4.

Decomposition:
- Shared package/header holds:
  - `WB_WIDTH`=8 and `WB_NREG`=4.
  - The entry record layout {rd, data}: field offsets as localparams.
- One sub-module is natural: `fila_wb`, a generic synchronous FIFO with async active-low reset. It exposes push/pop/head/cheio/vazio and per-entry visibility for `pend`.
- Arbitration, the `rw` gating and the `pend` reduction stay in `banco_writeback`.

Test Plan:
- Reset mid-operation: 3 entries queued, drop `r` between edges -> `rw`=0, `vazio`=1, `pend`=0 immediately. After release no writes issue and the bank is unchanged.
- Single write: `porta_ocupada`=0, `alu_valid`=1, rd=2, data=8'h5A for one cycle -> next cycle `rw`=1, `ra`=2, `dado`=8'h5A, and `pend`=4'b0100 during that cycle. The bank reg2 reads 8'h5A afterwards.
- Priority: `mem_valid` and `alu_valid` both high, mem rd=1 data=8'h11, alu rd=3 data=8'h33 -> `mem_ready`=1 and `alu_ready`=0. The memory entry is written first; the ALU entry is accepted one cycle later and written after it.
- Backpressure/full: `porta_ocupada`=1, push 4 entries 8'h01..8'h04 -> `cheio`=1, `alu_ready`=0 on the 5th offer. Then drop `porta_ocupada` -> 4 consecutive `rw` pulses carrying 01,02,03,04 in order, and pointers wrap correctly.
- Full with concurrent pop: FIFO full and `porta_ocupada`=0, offer 8'hAA -> accepted the same cycle; count stays 4; 8'hAA emerges 4th.
- Same-register ordering: queue rd=0 data=8'h10 then rd=0 data=8'h20 -> `pend`=4'b0001 until the second pop; the bank reg0 ends at 8'h20.
